cmd_boot_sequencer: RTL and testbench

//  Command initiator for the single-character UART command interface of the main control FSM.

---
 rtl/cmd_boot_sequencer_if.sv | 22 ++
 rtl/cmd_boot_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_cmd_boot_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_boot_sequencer_if.sv
// Command/response byte bus between the boot sequencer and the control FSM.
// The master drives command strobes and the slave returns response strobes.
interface cmd_boot_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic [7:0] rsp_data;
  logic       rsp_valid;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  rsp_data,
    input  rsp_valid
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output rsp_data,
    output rsp_valid
  );
endinterface

// File: rtl/cmd_boot_sequencer.sv
// Replays the power-up configuration script into the control FSM command
// port, checks each ack, and retries failed steps after an "R" reset.
module cmd_boot_sequencer #(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [9:0]  TRIG_V_CODE = 10'd512,
  parameter logic [6:0]  DATA_LEN    = 7'd125
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  cmd_boot_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          step,
  output logic [1:0]          retry_count
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [1:0]    RTY_MAX  = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_BIT,
    GAP,
    WAIT_ACK,
    SEND_RST,
    DONE,
    FAIL
  } state_e;

  state_e          state_q, state_d;
  state_e          nxt_q, nxt_d;
  logic [2:0]      step_q, step_d;
  logic [1:0]      retry_q, retry_d;
  logic [3:0]      bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   tmr_q, tmr_d;

  logic [7:0]      op_byte;
  logic [15:0]     payload;
  logic            has_pay;
  logic [3:0]      bit_top;
  logic [1:0]      retry_inc;
  logic            rsp_ack;
  logic            rsp_err;

  always_comb begin
    op_byte = 8'h54;
    case (step_q)
      3'd0:    op_byte = 8'h65;
      3'd1:    op_byte = 8'h4f;
      3'd2:    op_byte = 8'h57;
      3'd3:    op_byte = 8'h43;
      3'd4:    op_byte = 8'h56;
      3'd5:    op_byte = 8'h4d;
      default: op_byte = 8'h54;
    endcase
  end

  assign has_pay   = (step_q == 3'd4) || (step_q == 3'd5);
  assign bit_top   = (step_q == 3'd4) ? 4'd9 : 4'd6;
  assign payload   = (step_q == 3'd4) ? {6'd0, TRIG_V_CODE}
                                      : {9'd0, DATA_LEN};
  assign retry_inc = retry_q + 2'd1;
  assign rsp_ack   = bus.rsp_valid && (bus.rsp_data == 8'h2a);
  assign rsp_err   = bus.rsp_valid && (bus.rsp_data == 8'h21);

  always_comb begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    unique case (state_q)
      SEND_OP: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = op_byte;
      end
      SEND_BIT: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = payload[bit_q] ? 8'h31 : 8'h30;
      end
      SEND_RST: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h52;
      end
      default: ;
    endcase
  end

  assign busy        = !(state_q inside {IDLE, DONE, FAIL});
  assign done        = (state_q == DONE);
  assign error       = (state_q == FAIL);
  assign step        = step_q;
  assign retry_count = retry_q;

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    step_d  = step_q;
    retry_d = retry_q;
    bit_d   = bit_q;
    gap_d   = '0;
    tmr_d   = '0;
    unique case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_d = SEND_OP;
          step_d  = 3'd0;
          retry_d = 2'd0;
        end
      end
      SEND_OP: begin
        bit_d = bit_top;
        if (has_pay) begin
          nxt_d   = SEND_BIT;
          state_d = GAP;
        end else if (step_q == 3'd6) begin
          nxt_d   = DONE;
          state_d = GAP;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      SEND_BIT: begin
        if (bit_q == 4'd0) begin
          state_d = WAIT_ACK;
        end else begin
          bit_d   = bit_q - 4'd1;
          nxt_d   = SEND_BIT;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = nxt_q;
        else gap_d = gap_q + 1'b1;
      end
      WAIT_ACK: begin
        tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
        // An ack on the timeout cycle still counts as success.
        if (rsp_ack) begin
          step_d  = step_q + 3'd1;
          retry_d = 2'd0;
          nxt_d   = SEND_OP;
          state_d = GAP;
        end else if (rsp_err || tmr_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RTY_MAX) ? FAIL : SEND_RST;
        end
      end
      SEND_RST: begin
        nxt_d   = SEND_OP;
        state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      nxt_q   <= IDLE;
      step_q  <= 3'd0;
      retry_q <= 2'd0;
      bit_q   <= 4'd0;
      gap_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      step_q  <= step_d;
      retry_q <= retry_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: tb/tb_cmd_boot_sequencer.sv
// Self-checking bench: script strobes compared against a queue model built
// from the command table, with randomized ack delays and echo bytes.
module tb_cmd_boot_sequencer;

  localparam int GAP  = 4;
  localparam int TMO  = 16;
  localparam int MAXR = 3;
  localparam int TRIG = 512;
  localparam int DLEN = 125;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [2:0] step;
  logic [1:0] retry_count;

  cmd_boot_sequencer_if bus ();

  cmd_boot_sequencer #(
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(TMO),
    .MAX_RETRY  (MAXR),
    .TRIG_V_CODE(10'(TRIG)),
    .DATA_LEN   (7'(DLEN))
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .step       (step),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int total = 0;
  int first_t = 0;
  int last_t = 0;
  int t0 = 0;

  logic [7:0] got_q [$];
  int         gt_q  [$];
  logic [7:0] exp_q [$];
  logic [7:0] ops   [7] = '{8'h65, 8'h4f, 8'h57, 8'h43,
                            8'h56, 8'h4d, 8'h54};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.cmd_valid) begin
      got_q.push_back(bus.cmd_data);
      gt_q.push_back(cyc);
    end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_step(input int s);
    exp_q.push_back(ops[s]);
    if (s == 4)
      for (int i = 9; i >= 0; i--)
        exp_q.push_back(((TRIG >> i) & 1) != 0 ? 8'h31 : 8'h30);
    if (s == 5)
      for (int i = 6; i >= 0; i--)
        exp_q.push_back(((DLEN >> i) & 1) != 0 ? 8'h31 : 8'h30);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    int k = exp_q.size();
    int prev = 0;
    while (got_q.size() < k && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_cnt"}, 32'(got_q.size() >= k), 1);
    for (int i = 0; i < k; i++) begin
      logic [7:0] b;
      logic [7:0] e;
      int t;
      if (got_q.size() == 0) break;
      b = got_q.pop_front();
      t = gt_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_byte"}, b, e);
      if (i == 0) first_t = t;
      else check({tag, "_gap"}, t - prev, GAP + 1);
      prev = t;
      total++;
    end
    last_t = prev;
    exp_q.delete();
  endtask

  task automatic pulse_rsp(input logic [7:0] b);
    @(negedge clk);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = b;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ack_step(input int s, input int n_echo,
                          input logic [7:0] echo_b);
    push_step(s);
    drain($sformatf("s%0d", s));
    repeat ($urandom_range(1, 4)) @(negedge clk);
    for (int i = 0; i < n_echo; i++)
      pulse_rsp(echo_b != 8'h00 ? echo_b : 8'($urandom_range(48, 122)));
    pulse_rsp(8'h2a);
    check($sformatf("s%0d_adv", s), 32'(step), s + 1);
    check($sformatf("s%0d_rty", s), 32'(retry_count), 0);
  endtask

  task automatic finish_script(input string tag);
    push_step(6);
    drain({tag, "_s6"});
    repeat (GAP + 3) @(negedge clk);
    #1;
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_step"}, 32'(step), 6);
    check({tag, "_err"}, 32'(error), 0);
  endtask

  initial begin
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(bus.cmd_valid), 0);
    check("rst_data", 32'(bus.cmd_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    check("rst_step", 32'(step), 0);
    check("rst_rty", 32'(retry_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // full script, echo 'W' bytes before the step 2 ack
    total = 0;
    pulse_start();
    #1;
    check("t2_busy", 32'(busy), 1);
    ack_step(0, $urandom_range(0, 2), 8'h00);
    ack_step(1, $urandom_range(0, 2), 8'h00);
    ack_step(2, 2, 8'h57);
    ack_step(3, $urandom_range(0, 2), 8'h00);
    ack_step(4, $urandom_range(0, 2), 8'h00);
    ack_step(5, $urandom_range(0, 2), 8'h00);
    finish_script("t2");
    check("t2_total", total, 24);

    // '!' on step 4 first attempt
    pulse_start();
    for (int s = 0; s < 4; s++) ack_step(s, $urandom_range(0, 2), 8'h00);
    push_step(4);
    drain("t4_first");
    repeat ($urandom_range(1, 4)) @(negedge clk);
    pulse_rsp(8'h21);
    check("t4_rty1", 32'(retry_count), 1);
    exp_q.push_back(8'h52);
    push_step(4);
    drain("t4_retry");
    check("t4_rty_hold", 32'(retry_count), 1);
    check("t4_step_hold", 32'(step), 4);
    pulse_rsp(8'h2a);
    check("t4_adv", 32'(step), 5);
    check("t4_rty0", 32'(retry_count), 0);
    ack_step(5, $urandom_range(0, 2), 8'h00);
    finish_script("t4");

    // silent responder on step 1
    pulse_start();
    ack_step(0, $urandom_range(0, 2), 8'h00);
    push_step(1);
    drain("t5_o");
    for (int r = 1; r < MAXR; r++) begin
      t0 = last_t;
      exp_q.push_back(8'h52);
      push_step(1);
      drain($sformatf("t5_r%0d", r));
      check("t5_tmo_lat", first_t - t0, TMO + 1);
      check("t5_rty", 32'(retry_count), r);
    end
    repeat (TMO + 6) @(negedge clk);
    #1;
    check("t5_err", 32'(error), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_step", 32'(step), 1);
    check("t5_rty_max", 32'(retry_count), MAXR);
    check("t5_quiet", got_q.size(), 0);

    // restart from FAIL, then start while busy and '*' during GAP
    pulse_start();
    push_step(0);
    drain("t6_e");
    check("t6_step0", 32'(step), 0);
    check("t6_err0", 32'(error), 0);
    pulse_start();
    pulse_rsp(8'h2a);
    check("t6_adv", 32'(step), 1);
    pulse_rsp(8'h2a);
    pulse_start();
    push_step(1);
    drain("t6_o");
    repeat (4) @(negedge clk);
    #1;
    check("t6_no_buf", 32'(step), 1);
    check("t6_busy", 32'(busy), 1);
    pulse_rsp(8'h2a);
    check("t6_adv2", 32'(step), 2);
    ack_step(2, $urandom_range(0, 2), 8'h00);
    ack_step(3, $urandom_range(0, 2), 8'h00);

    // reset mid-bit of step 4
    begin
      int n = 0;
      while (got_q.size() < 3 && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    check("t1_pre", 32'(bus.cmd_valid), 1);
    reset_n = 1'b0;
    #1;
    check("t1_valid", 32'(bus.cmd_valid), 0);
    check("t1_data", 32'(bus.cmd_data), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_step", 32'(step), 0);
    check("t1_rty", 32'(retry_count), 0);
    check("t1_flags", 32'({done, error}), 0);
    repeat (3) @(negedge clk);
    got_q.delete();
    gt_q.delete();
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("t1_quiet", got_q.size(), 0);
    check("t1_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
